// File: rtl/timer_pkg.sv
// Shared defines for the timer: bus widths, register offsets and CTRL layout.
package timer_pkg;

   localparam int unsigned CPU_WIDTH = 32;
   localparam int unsigned INT_BUS   = 8;

   localparam logic [INT_BUS-1:0] INT_NONE = '0;

   // Byte offsets of the mapped registers (0xC is unmapped)
   localparam logic [3:0] OFF_CTRL  = 4'h0;
   localparam logic [3:0] OFF_COUNT = 4'h4;
   localparam logic [3:0] OFF_VALUE = 4'h8;

   // CTRL bit positions
   localparam int unsigned CTRL_EN   = 0;
   localparam int unsigned CTRL_IE   = 1;
   localparam int unsigned CTRL_PEND = 2;
   localparam int unsigned CTRL_AR   = 3;

   // CTRL register contents, packed so that bit order matches the map
   typedef struct packed {
      logic ar;
      logic pend;
      logic ie;
      logic en;
   } ctrl_t;

   // CTRL as seen on the bus; upper bits read as zero
   function automatic logic [CPU_WIDTH-1:0] ctrl_read(input ctrl_t c);
      return CPU_WIDTH'(c);
   endfunction

endpackage

// File: rtl/timer.sv
// Memory-mapped up-counter with compare match, one-shot/auto-reload and a
// level interrupt on one bit of the shared interrupt bus.
module timer
   import timer_pkg::*;
#(
   parameter int unsigned INT_ID = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_i,
   input  logic                 we_i,
   input  logic [CPU_WIDTH-1:0] addr_i,
   input  logic [CPU_WIDTH-1:0] wdata_i,
   output logic [CPU_WIDTH-1:0] rdata_o,
   output logic                 ack_o,
   output logic [INT_BUS-1:0]   int_flag_o
);

   ctrl_t                ctrl_q, ctrl_d;
   logic [CPU_WIDTH-1:0] count_q, count_d;
   logic [CPU_WIDTH-1:0] value_q, value_d;

   logic                 wr_ctrl_c, wr_count_c, wr_value_c;
   logic                 rd_c;
   logic                 match_c;
   logic [3:0]           offset_c;
   logic [CPU_WIDTH-1:0] read_mux_c;
   logic [INT_BUS-1:0]   int_flag_d;

   // Only addr_i[3:2] selects a register; the rest of the address is ignored
   logic unused_addr;
   assign unused_addr = ^{addr_i[CPU_WIDTH-1:4], addr_i[1:0]};

   // Bus-slave decode: register strobes and read mux from current state
   always_comb begin
      wr_ctrl_c  = 1'b0;
      wr_count_c = 1'b0;
      wr_value_c = 1'b0;
      rd_c       = req_i & ~we_i;
      read_mux_c = '0;
      offset_c   = {addr_i[3:2], 2'b00};
      case (offset_c)
         OFF_CTRL: begin
            wr_ctrl_c  = req_i & we_i;
            read_mux_c = ctrl_read(ctrl_q);
         end
         OFF_COUNT: begin
            wr_count_c = req_i & we_i;
            read_mux_c = count_q;
         end
         OFF_VALUE: begin
            wr_value_c = req_i & we_i;
            read_mux_c = value_q;
         end
         default: begin
            read_mux_c = '0;
         end
      endcase
   end

   // Bus response: ack every request one cycle later, read data only on reads
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_o   <= 1'b0;
         rdata_o <= '0;
      end else begin
         ack_o   <= req_i;
         rdata_o <= rd_c ? read_mux_c : '0;
      end
   end

   // Counter next state; later assignments carry the write/match priorities
   always_comb begin
      ctrl_d  = ctrl_q;
      count_d = count_q;
      value_d = value_q;
      match_c = ctrl_q.en & (count_q == value_q);

      if (ctrl_q.en) begin
         count_d = match_c ? '0 : count_q + CPU_WIDTH'(1);
      end
      if (match_c && !ctrl_q.ar) begin
         ctrl_d.en = 1'b0;
      end

      // A CTRL write overrides the one-shot disable; PEND is write-1-to-clear
      if (wr_ctrl_c) begin
         ctrl_d.en = wdata_i[CTRL_EN];
         ctrl_d.ie = wdata_i[CTRL_IE];
         ctrl_d.ar = wdata_i[CTRL_AR];
         if (wdata_i[CTRL_PEND]) begin
            ctrl_d.pend = 1'b0;
         end
      end

      // A match sets PEND even against a simultaneous clear
      if (match_c) begin
         ctrl_d.pend = 1'b1;
      end

      // A COUNT write beats both increment and match reset
      if (wr_count_c) begin
         count_d = wdata_i;
      end
      if (wr_value_c) begin
         value_d = wdata_i;
      end

      int_flag_d = (ctrl_d.pend & ctrl_d.ie) ? (INT_BUS'(1) << INT_ID) : INT_NONE;
   end

   // Counter state and interrupt level, registered together so the flag tracks PEND
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q     <= '0;
         count_q    <= '0;
         value_q    <= '0;
         int_flag_o <= INT_NONE;
      end else begin
         ctrl_q     <= ctrl_d;
         count_q    <= count_d;
         value_q    <= value_d;
         int_flag_o <= int_flag_d;
      end
   end

endmodule
